// File: rtl/time_set_uart_rx.sv
// time_set_uart_rx: UART "T"HHMMSS<CR> time-set receiver; `define TIME_RX_PARITY_EN adds an even-parity bit (8E1).
module time_set_uart_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int MAX_HOURS = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       rx_oeb,
  output logic [5:0] set_hours,
  output logic [5:0] set_minutes,
  output logic [5:0] set_seconds,
  output logic       set_valid,
  output logic       frame_err
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
`ifdef TIME_RX_PARITY_EN
  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_PARITY, B_STOP} bstate_t;
`else
  typedef enum logic [2:0] {B_IDLE, B_START, B_DATA, B_STOP} bstate_t;
`endif
  typedef enum logic [1:0] {F_WAIT_T, F_DIGITS, F_WAIT_CR} fstate_t;
  bstate_t bstate, bstate_n;
  fstate_t fstate, fstate_n;
  logic rx_s1, rxs;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] idx, idx_n, didx, didx_n;
  logic [7:0] sh, sh_n;
  logic byte_ok, byte_err;
  logic [3:0] dig [6];
  logic [3:0] dig_n [6];
  logic [5:0] hours_n, minutes_n, seconds_n;
  logic valid_n, err_n;
  logic [6:0] hr7, mn7, sc7;
  logic range_ok;
`ifdef TIME_RX_PARITY_EN
  logic perr, perr_n;
`endif
  assign rx_oeb = 1'b1;
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rxs <= 1'b1;
      bstate <= B_IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
`ifdef TIME_RX_PARITY_EN
      perr <= 1'b0;
`endif
    end else begin
      rx_s1 <= rx;
      rxs <= rx_s1;
      bstate <= bstate_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
`ifdef TIME_RX_PARITY_EN
      perr <= perr_n;
`endif
    end
  end
  always_comb begin
    bstate_n = bstate;
    cnt_n = cnt + 1'b1;
    idx_n = idx;
    sh_n = sh;
    byte_ok = 1'b0;
    byte_err = 1'b0;
`ifdef TIME_RX_PARITY_EN
    perr_n = perr;
`endif
    case (bstate)
      B_IDLE: begin
        cnt_n = '0;
        bstate_n = rxs ? B_IDLE : B_START;
      end
      B_START: if (cnt == HALF) begin
        cnt_n = '0;
        idx_n = '0;
        bstate_n = rxs ? B_IDLE : B_DATA;
      end
      B_DATA: if (cnt == FULL) begin
        cnt_n = '0;
        sh_n = {rxs, sh[7:1]};
        idx_n = idx + 1'b1;
`ifdef TIME_RX_PARITY_EN
        bstate_n = (idx == 3'd7) ? B_PARITY : B_DATA;
`else
        bstate_n = (idx == 3'd7) ? B_STOP : B_DATA;
`endif
      end
`ifdef TIME_RX_PARITY_EN
      // a parity mismatch is held until the stop sample so bit timing stays intact
      B_PARITY: if (cnt == FULL) begin
        cnt_n = '0;
        perr_n = rxs ^ (^sh);
        bstate_n = B_STOP;
      end
`endif
      B_STOP: if (cnt == FULL) begin
        cnt_n = '0;
        bstate_n = B_IDLE;
`ifdef TIME_RX_PARITY_EN
        byte_ok = rxs & ~perr;
        byte_err = ~rxs | perr;
`else
        byte_ok = rxs;
        byte_err = ~rxs;
`endif
      end
      default: bstate_n = B_IDLE;
    endcase
  end
  assign hr7 = 7'(dig[0]) * 7'd10 + 7'(dig[1]);
  assign mn7 = 7'(dig[2]) * 7'd10 + 7'(dig[3]);
  assign sc7 = 7'(dig[4]) * 7'd10 + 7'(dig[5]);
  assign range_ok = (int'(hr7) < MAX_HOURS) && (mn7 < 7'd60) && (sc7 < 7'd60);
  always_ff @(posedge clk) begin
    if (reset) begin
      fstate <= F_WAIT_T;
      didx <= '0;
      dig <= '{default: '0};
      set_hours <= '0;
      set_minutes <= '0;
      set_seconds <= '0;
      set_valid <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      fstate <= fstate_n;
      didx <= didx_n;
      dig <= dig_n;
      set_hours <= hours_n;
      set_minutes <= minutes_n;
      set_seconds <= seconds_n;
      set_valid <= valid_n;
      frame_err <= err_n;
    end
  end
  always_comb begin
    fstate_n = fstate;
    didx_n = didx;
    dig_n = dig;
    hours_n = set_hours;
    minutes_n = set_minutes;
    seconds_n = set_seconds;
    valid_n = 1'b0;
    err_n = 1'b0;
    if (byte_ok && sh == 8'h54) begin
      fstate_n = F_DIGITS;
      didx_n = '0;
    end else if (byte_ok || byte_err) begin
      case (fstate)
        F_DIGITS: if (byte_ok && sh >= 8'h30 && sh <= 8'h39) begin
          dig_n[didx] = sh[3:0];
          didx_n = didx + 1'b1;
          fstate_n = (didx == 3'd5) ? F_WAIT_CR : F_DIGITS;
        end else begin
          err_n = 1'b1;
          fstate_n = F_WAIT_T;
        end
        F_WAIT_CR: begin
          fstate_n = F_WAIT_T;
          valid_n = byte_ok && sh == 8'h0D && range_ok;
          err_n = ~valid_n;
          hours_n = valid_n ? hr7[5:0] : set_hours;
          minutes_n = valid_n ? mn7[5:0] : set_minutes;
          seconds_n = valid_n ? sc7[5:0] : set_seconds;
        end
        default: fstate_n = F_WAIT_T;
      endcase
    end
  end
endmodule
